write_back_pipe: RTL and testbench

- Parametrised successor to the combinational write-back mux.
- Owns the MEM/WB pipeline register, with stall and flush control.
- Performs load-data alignment and sign/zero extension (LB/LH/LW/LBU/LHU).
- Selects among four result sources, suppresses writes to x0, and keeps a retired-instruction counter. Drives the register-file write port and the WB forwarding path back to ID/EX.

---
 rtl/rv_pkg.sv | 18 +
 rtl/write_back_pipe_if.sv | 45 ++++
 rtl/load_align.sv | 39 +++
 rtl/write_back_pipe.sv | 114 +++++++++++
 tb/tb_write_back_pipe.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV encodings used by the write-back pipe and, later, the LSU.
// Result-select encodings, load funct3 values and the default datapath width.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_AUX  = 2'd3;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/write_back_pipe_if.sv
// MEM/WB bundle: the MEM side drives the *_mem_wb fields and stage control,
// the pipe drives the register-file write port, valid flag and retire count.
interface write_back_pipe_if
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
);
    logic             stall_wb;
    logic             flush_wb;
    logic             valid_mem_wb;
    logic [1:0]       wb_sel_mem_wb;
    logic [2:0]       load_funct3_mem_wb;
    logic [1:0]       addr_lo_mem_wb;
    logic [XLEN-1:0]  alu_out_mem_wb;
    logic [XLEN-1:0]  r_data_mem_wb;
    logic [XLEN-1:0]  pc_plus4_mem_wb;
    logic [XLEN-1:0]  aux_mem_wb;
    logic             write_reg_enable_mem_wb;
    logic [RA_W-1:0]  write_reg_mem_wb;

    logic [XLEN-1:0]  write_data_wb_id;
    logic             write_reg_enable_wb_id;
    logic [RA_W-1:0]  write_reg_wb_id;
    logic             valid_wb;
    logic [CNT_W-1:0] instret_wb;

    modport master (
        output stall_wb, flush_wb, valid_mem_wb, wb_sel_mem_wb, load_funct3_mem_wb,
               addr_lo_mem_wb, alu_out_mem_wb, r_data_mem_wb, pc_plus4_mem_wb,
               aux_mem_wb, write_reg_enable_mem_wb, write_reg_mem_wb,
        input  write_data_wb_id, write_reg_enable_wb_id, write_reg_wb_id,
               valid_wb, instret_wb
    );

    modport slave (
        input  stall_wb, flush_wb, valid_mem_wb, wb_sel_mem_wb, load_funct3_mem_wb,
               addr_lo_mem_wb, alu_out_mem_wb, r_data_mem_wb, pc_plus4_mem_wb,
               aux_mem_wb, write_reg_enable_mem_wb, write_reg_mem_wb,
        output write_data_wb_id, write_reg_enable_wb_id, write_reg_wb_id,
               valid_wb, instret_wb
    );

endinterface

// File: rtl/load_align.sv
// Combinational load lane extraction and sign/zero extension.
// Misaligned halfwords are trapped upstream, so addr_lo[0] is ignored for LH/LHU.
module load_align
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] raw_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw_data[7:0];
        case (addr_lo)
            2'd1:    byte_lane = raw_data[15:8];
            2'd2:    byte_lane = raw_data[23:16];
            2'd3:    byte_lane = raw_data[31:24];
            default: byte_lane = raw_data[7:0];
        endcase
        half_lane = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];

        // Unlisted funct3 codes pass the raw word through untouched.
        load_data = raw_data;
        case (funct3)
            LOAD_LB:  load_data = XLEN'($signed(byte_lane));
            LOAD_LBU: load_data = XLEN'(byte_lane);
            LOAD_LH:  load_data = XLEN'($signed(half_lane));
            LOAD_LHU: load_data = XLEN'(half_lane);
            LOAD_LW:  load_data = XLEN'($signed(raw_data[31:0]));
            default:  load_data = raw_data;
        endcase
    end

endmodule

// File: rtl/write_back_pipe.sv
// MEM/WB pipeline register with stall/flush, load alignment, result select,
// x0 write suppression and a retired-instruction counter.
module write_back_pipe
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input logic              clk,
    input logic              rst,
    write_back_pipe_if.slave bus
);

    logic             valid_q,   valid_d;
    logic [1:0]       wb_sel_q,  wb_sel_d;
    logic [2:0]       funct3_q,  funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]  alu_q,     alu_d;
    logic [XLEN-1:0]  r_data_q,  r_data_d;
    logic [XLEN-1:0]  pc4_q,     pc4_d;
    logic [XLEN-1:0]  aux_q,     aux_d;
    logic             we_q,      we_d;
    logic [RA_W-1:0]  rd_q,      rd_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  load_data;

    // An instruction retires on any edge where it leaves WB unstalled, even if
    // the incoming slot is being flushed at the same time.
    always_comb begin
        valid_d   = valid_q;
        wb_sel_d  = wb_sel_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        alu_d     = alu_q;
        r_data_d  = r_data_q;
        pc4_d     = pc4_q;
        aux_d     = aux_q;
        we_d      = we_q;
        rd_d      = rd_q;
        instret_d = instret_q;

        if (valid_q && !bus.stall_wb) begin
            instret_d = instret_q + CNT_W'(1);
        end

        if (bus.flush_wb) begin
            valid_d = 1'b0;
        end else if (!bus.stall_wb) begin
            valid_d   = bus.valid_mem_wb;
            wb_sel_d  = bus.wb_sel_mem_wb;
            funct3_d  = bus.load_funct3_mem_wb;
            addr_lo_d = bus.addr_lo_mem_wb;
            alu_d     = bus.alu_out_mem_wb;
            r_data_d  = bus.r_data_mem_wb;
            pc4_d     = bus.pc_plus4_mem_wb;
            aux_d     = bus.aux_mem_wb;
            we_d      = bus.write_reg_enable_mem_wb;
            rd_d      = bus.write_reg_mem_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wb_sel_q  <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            alu_q     <= '0;
            r_data_q  <= '0;
            pc4_q     <= '0;
            aux_q     <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            wb_sel_q  <= wb_sel_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            alu_q     <= alu_d;
            r_data_q  <= r_data_d;
            pc4_q     <= pc4_d;
            aux_q     <= aux_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            instret_q <= instret_d;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw_data  (r_data_q),
        .funct3    (funct3_q),
        .addr_lo   (addr_lo_q),
        .load_data (load_data)
    );

    // Write data is driven regardless of the strobe; consumers must qualify it.
    always_comb begin
        bus.write_data_wb_id = alu_q;
        case (wb_sel_q)
            WB_SEL_LOAD: bus.write_data_wb_id = load_data;
            WB_SEL_PC4:  bus.write_data_wb_id = pc4_q;
            WB_SEL_AUX:  bus.write_data_wb_id = aux_q;
            default:     bus.write_data_wb_id = alu_q;
        endcase
    end

    assign bus.write_reg_enable_wb_id = valid_q & we_q & (rd_q != '0);
    assign bus.write_reg_wb_id        = rd_q;
    assign bus.valid_wb               = valid_q;
    assign bus.instret_wb             = instret_q;

endmodule

// File: tb/tb_write_back_pipe.sv
// Self-checking bench for write_back_pipe: vector table plus hand-written
// stall/flush/reset/wrap sequences, checked through an expected-result queue.
module tb_write_back_pipe;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        valid;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [1:0]  alo;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] aux;
      logic        en;
      logic [4:0]  rd;
      logic        chk_data;
      logic [31:0] exp_data;
      logic        exp_we;
      logic [4:0]  exp_rd;
   } vec_t;

   typedef struct {
      logic        chk_data;
      logic [31:0] data;
      logic        we;
      logic [4:0]  rd;
      logic        valid;
      logic [3:0]  instret;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t expQ[$];
   logic modelValid;
   logic [3:0] expInstret;
   logic [3:0] holdCnt;
   vec_t tbl[18];
   vec_t v;

   write_back_pipe_if #(.XLEN(32), .RA_W(5), .CNT_W(4)) bus();

   write_back_pipe #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock; inputs change on the falling edge, outputs are sampled there too.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the test finished");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mkVec(input logic [1:0] sel, input logic [2:0] f3,
                                  input logic [1:0] alo, input logic [4:0] rd,
                                  input logic en, input logic valid,
                                  input logic [31:0] expData, input logic expWe);
      vec_t r;
      r.stall    = 1'b0;
      r.flush    = 1'b0;
      r.valid    = valid;
      r.sel      = sel;
      r.f3       = f3;
      r.alo      = alo;
      r.rdata    = 32'h80F1_7F82;
      r.alu      = 32'h0000_00A1;
      r.pc4      = 32'h0000_0104;
      r.aux      = 32'hCAFE_0000;
      r.en       = en;
      r.rd       = rd;
      r.chk_data = 1'b1;
      r.exp_data = expData;
      r.exp_we   = expWe;
      r.exp_rd   = rd;
      return r;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic driveIdle();
      bus.stall_wb                = 1'b0;
      bus.flush_wb                = 1'b0;
      bus.valid_mem_wb            = 1'b0;
      bus.wb_sel_mem_wb           = 2'd0;
      bus.load_funct3_mem_wb      = 3'd0;
      bus.addr_lo_mem_wb          = 2'd0;
      bus.alu_out_mem_wb          = 32'd0;
      bus.r_data_mem_wb           = 32'd0;
      bus.pc_plus4_mem_wb         = 32'd0;
      bus.aux_mem_wb              = 32'd0;
      bus.write_reg_enable_mem_wb = 1'b0;
      bus.write_reg_mem_wb        = 5'd0;
   endtask

   // Drive one cycle of stimulus and push what WB should show after the next edge.
   task automatic applyStimulus(input vec_t s);
      exp_t e;
      bus.stall_wb                = s.stall;
      bus.flush_wb                = s.flush;
      bus.valid_mem_wb            = s.valid;
      bus.wb_sel_mem_wb           = s.sel;
      bus.load_funct3_mem_wb      = s.f3;
      bus.addr_lo_mem_wb          = s.alo;
      bus.alu_out_mem_wb          = s.alu;
      bus.r_data_mem_wb           = s.rdata;
      bus.pc_plus4_mem_wb         = s.pc4;
      bus.aux_mem_wb              = s.aux;
      bus.write_reg_enable_mem_wb = s.en;
      bus.write_reg_mem_wb        = s.rd;
      if (modelValid && !s.stall) expInstret = expInstret + 4'd1;
      if (s.flush) modelValid = 1'b0;
      else if (!s.stall) modelValid = s.valid;
      e.chk_data = s.chk_data;
      e.data     = s.exp_data;
      e.we       = s.exp_we;
      e.rd       = s.exp_rd;
      e.valid    = modelValid;
      e.instret  = expInstret;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      @(negedge clk);
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s scoreboard empty actual=0 expected=1", tag);
      end else begin
         e = expQ.pop_front();
         checkVal({tag, " valid"}, 64'(bus.valid_wb), 64'(e.valid));
         checkVal({tag, " we"}, 64'(bus.write_reg_enable_wb_id), 64'(e.we));
         checkVal({tag, " instret"}, 64'(bus.instret_wb), 64'(e.instret));
         if (e.chk_data) begin
            checkVal({tag, " data"}, 64'(bus.write_data_wb_id), 64'(e.data));
            checkVal({tag, " rd"}, 64'(bus.write_reg_wb_id), 64'(e.rd));
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, " data"}, 64'(bus.write_data_wb_id), 64'd0);
      checkVal({tag, " we"}, 64'(bus.write_reg_enable_wb_id), 64'd0);
      checkVal({tag, " rd"}, 64'(bus.write_reg_wb_id), 64'd0);
      checkVal({tag, " valid"}, 64'(bus.valid_wb), 64'd0);
      checkVal({tag, " instret"}, 64'(bus.instret_wb), 64'd0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      modelValid = 1'b0;
      expInstret = 4'd0;
      rst        = 1'b1;
      driveIdle();

      tbl[0]  = mkVec(2'd1, 3'b000, 2'd0, 5'd1,  1'b1, 1'b1, 32'hFFFF_FF82, 1'b1);
      tbl[1]  = mkVec(2'd1, 3'b000, 2'd1, 5'd2,  1'b1, 1'b1, 32'h0000_007F, 1'b1);
      tbl[2]  = mkVec(2'd1, 3'b000, 2'd2, 5'd3,  1'b1, 1'b1, 32'hFFFF_FFF1, 1'b1);
      tbl[3]  = mkVec(2'd1, 3'b000, 2'd3, 5'd4,  1'b1, 1'b1, 32'hFFFF_FF80, 1'b1);
      tbl[4]  = mkVec(2'd1, 3'b100, 2'd3, 5'd5,  1'b1, 1'b1, 32'h0000_0080, 1'b1);
      tbl[5]  = mkVec(2'd1, 3'b001, 2'd2, 5'd6,  1'b1, 1'b1, 32'hFFFF_80F1, 1'b1);
      tbl[6]  = mkVec(2'd1, 3'b101, 2'd2, 5'd7,  1'b1, 1'b1, 32'h0000_80F1, 1'b1);
      tbl[7]  = mkVec(2'd1, 3'b001, 2'd0, 5'd8,  1'b1, 1'b1, 32'h0000_7F82, 1'b1);
      tbl[8]  = mkVec(2'd1, 3'b010, 2'd1, 5'd9,  1'b1, 1'b1, 32'h80F1_7F82, 1'b1);
      tbl[9]  = mkVec(2'd1, 3'b011, 2'd2, 5'd10, 1'b1, 1'b1, 32'h80F1_7F82, 1'b1);
      tbl[10] = mkVec(2'd1, 3'b101, 2'd3, 5'd11, 1'b1, 1'b1, 32'h0000_80F1, 1'b1);
      tbl[11] = mkVec(2'd1, 3'b001, 2'd1, 5'd12, 1'b1, 1'b1, 32'h0000_7F82, 1'b1);
      tbl[12] = mkVec(2'd2, 3'b000, 2'd0, 5'd0,  1'b1, 1'b1, 32'h0000_0104, 1'b0);
      tbl[13] = mkVec(2'd0, 3'b000, 2'd0, 5'd5,  1'b1, 1'b1, 32'h0000_00A1, 1'b1);
      tbl[14] = mkVec(2'd3, 3'b000, 2'd0, 5'd31, 1'b0, 1'b1, 32'hCAFE_0000, 1'b0);
      tbl[15] = mkVec(2'd0, 3'b000, 2'd0, 5'd3,  1'b1, 1'b0, 32'h0000_00A1, 1'b0);
      tbl[16] = mkVec(2'd1, 3'b100, 2'd1, 5'd13, 1'b1, 1'b1, 32'h0000_007F, 1'b1);
      tbl[17] = mkVec(2'd1, 3'b110, 2'd0, 5'd14, 1'b1, 1'b1, 32'h80F1_7F82, 1'b1);

      repeat (2) @(negedge clk);
      checkAllZero("in_reset");
      rst = 1'b0;
      #1;
      checkAllZero("after_release");

      for (int i = 0; i < 18; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vec%0d", i));
      end

      // Stall: the held instruction must stay visible and retire exactly once.
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd5, 1'b1, 1'b1, 32'h0000_1234, 1'b1);
      v.alu = 32'h0000_1234;
      applyStimulus(v);
      checkOutput("stall_load");
      holdCnt = expInstret;
      for (int i = 0; i < 3; i++) begin
         v = mkVec(2'd0, 3'b000, 2'd0, 5'd9, 1'b1, 1'b1, 32'h0000_1234, 1'b1);
         v.alu    = 32'h0000_DEAD;
         v.stall  = 1'b1;
         v.exp_rd = 5'd5;
         applyStimulus(v);
         checkOutput($sformatf("stall_hold%0d", i));
         checkVal("stall_no_count", 64'(bus.instret_wb), 64'(holdCnt));
      end
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd6, 1'b1, 1'b1, 32'h0000_0077, 1'b1);
      v.alu = 32'h0000_0077;
      applyStimulus(v);
      checkOutput("stall_release");
      checkVal("stall_retire_once", 64'(bus.instret_wb), 64'(holdCnt + 4'd1));

      // Stall and flush together: slot empties, held instruction is not counted.
      holdCnt = expInstret;
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd7, 1'b1, 1'b1, 32'h0, 1'b0);
      v.stall    = 1'b1;
      v.flush    = 1'b1;
      v.chk_data = 1'b0;
      applyStimulus(v);
      checkOutput("stall_flush");
      checkVal("stall_flush_valid", 64'(bus.valid_wb), 64'd0);
      checkVal("stall_flush_cnt", 64'(bus.instret_wb), 64'(holdCnt));

      // Flush alone with a valid instruction in WB: that instruction still retires.
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd8, 1'b1, 1'b1, 32'h0000_00A1, 1'b1);
      applyStimulus(v);
      checkOutput("pre_flush");
      holdCnt = expInstret;
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd9, 1'b1, 1'b1, 32'h0, 1'b0);
      v.flush    = 1'b1;
      v.chk_data = 1'b0;
      applyStimulus(v);
      checkOutput("flush_only");
      checkVal("flush_retires", 64'(bus.instret_wb), 64'(holdCnt + 4'd1));

      // Asynchronous reset in the middle of a cycle with a valid instruction in WB.
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd10, 1'b1, 1'b1, 32'h0000_00A1, 1'b1);
      applyStimulus(v);
      checkOutput("pre_reset");
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("mid_reset");
      expQ.delete();
      modelValid = 1'b0;
      expInstret = 4'd0;
      driveIdle();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkAllZero("mid_reset_release");

      // Counter wrap with a 4-bit counter.
      for (int i = 0; i < 40 && expInstret != 4'd15; i++) begin
         v = mkVec(2'd0, 3'b000, 2'd0, 5'((i % 31) + 1), 1'b1, 1'b1, 32'(i), 1'b1);
         v.alu = 32'(i);
         applyStimulus(v);
         checkOutput($sformatf("preload%0d", i));
      end
      checkVal("preload_15", 64'(bus.instret_wb), 64'd15);
      v = mkVec(2'd0, 3'b000, 2'd0, 5'd1, 1'b1, 1'b1, 32'h0000_00A1, 1'b1);
      applyStimulus(v);
      checkOutput("wrap_step");
      checkVal("wrap", 64'(bus.instret_wb), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
